// File: rtl/histogram_pkg.sv
// Shared constants, width derivations and state encoding for the histogram blocks.
package histogram_pkg;

  localparam int C_QUANTITY    = 16;
  localparam int C_COUNT_WIDTH = 16;
  localparam int C_DATA_WIDTH  = 8;

  function automatic int sum_width(input int quantity, input int count_width);
    return count_width + $clog2(quantity);
  endfunction

  localparam int SUM_W = sum_width(C_QUANTITY, C_COUNT_WIDTH);
  localparam int P     = SUM_W + C_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_NORM  = 2'd2
  } hist_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, start/done handshake.
module seq_divider #(
  parameter int DW = 28,
  parameter int VW = 20,
  parameter int QW = 8
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          start_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [VW-1:0] divisor_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [QW-1:0] quotient_o
);

  localparam int CW = $clog2(DW + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] rem_q, rem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] div_q, div_d;
  logic [VW:0]   rem_shift;
  logic [VW:0]   diff;
  logic          ge;

  // start_i is taken only while busy_o is low; done_o pulses on the final
  // iteration cycle and quotient_o is valid only in that cycle.
  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    done_o    = 1'b0;
    rem_shift = {rem_q, quo_q[DW-1]};
    diff      = rem_shift - {1'b0, div_q};
    ge        = ~diff[VW];
    if (busy_q) begin
      rem_d = ge ? diff[VW-1:0] : rem_shift[VW-1:0];
      quo_d = {quo_q[DW-2:0], ge};
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_o = 1'b1;
      end
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CW'(DW);
      rem_d  = '0;
      quo_d  = dividend_i;
      div_d  = divisor_i;
    end
    quotient_o = quo_d[QW-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/histogram_cdf.sv
// Accumulates a histogram frame into a CDF, then emits one equalised level per bin.
module histogram_cdf
  import histogram_pkg::*;
#(
  parameter int C_QUANTITY    = histogram_pkg::C_QUANTITY,
  parameter int C_COUNT_WIDTH = histogram_pkg::C_COUNT_WIDTH,
  parameter int C_DATA_WIDTH  = histogram_pkg::C_DATA_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     valid_i,
  input  logic                     last_i,
  input  logic [C_COUNT_WIDTH-1:0] data_i,
  output logic                     busy_o,
  output logic                     valid_o,
  output logic                     last_o,
  output logic [C_DATA_WIDTH-1:0]  data_o,
  output hist_state_e              state_o
);

  localparam int SUM_BITS  = sum_width(C_QUANTITY, C_COUNT_WIDTH);
  localparam int PROD_BITS = SUM_BITS + C_DATA_WIDTH;
  localparam int IW        = $clog2(C_QUANTITY + 1);
  localparam int AW        = (C_QUANTITY > 1) ? $clog2(C_QUANTITY) : 1;

  hist_state_e             state_q, state_d;
  logic [SUM_BITS-1:0]     sum_q, sum_d;
  logic [IW-1:0]           acc_n_q, acc_n_d;
  logic [IW-1:0]           lnch_q, lnch_d;
  logic                    valid_o_q, valid_o_d;
  logic                    last_o_q, last_o_d;
  logic [C_DATA_WIDTH-1:0] data_o_q, data_o_d;
  logic [SUM_BITS-1:0]     cdf_q [C_QUANTITY];
  logic [SUM_BITS-1:0]     cdf_d [C_QUANTITY];

  logic [SUM_BITS-1:0]     sum_new;
  logic [SUM_BITS-1:0]     numer;
  logic [PROD_BITS-1:0]    dividend;
  logic                    div_start;
  logic                    div_busy;
  logic                    div_done;
  logic [C_DATA_WIDTH-1:0] div_quo;

  // Bins past an early last_i were never written; they read as the total.
  always_comb begin
    numer    = (lnch_q < acc_n_q) ? cdf_q[lnch_q[AW-1:0]] : sum_q;
    dividend = {numer, {C_DATA_WIDTH{1'b0}}} - PROD_BITS'(numer);
  end

  seq_divider #(
    .DW (PROD_BITS),
    .VW (SUM_BITS),
    .QW (C_DATA_WIDTH)
  ) u_div (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .start_i    (div_start),
    .dividend_i (dividend),
    .divisor_i  (sum_q),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    acc_n_d   = acc_n_q;
    lnch_d    = lnch_q;
    valid_o_d = 1'b0;
    last_o_d  = 1'b0;
    data_o_d  = data_o_q;
    cdf_d     = cdf_q;
    div_start = 1'b0;
    sum_new   = sum_q + SUM_BITS'(data_i);
    unique case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          sum_d    = SUM_BITS'(data_i);
          cdf_d[0] = SUM_BITS'(data_i);
          acc_n_d  = IW'(1);
          lnch_d   = '0;
          state_d  = (last_i || C_QUANTITY == 1) ? ST_NORM : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (valid_i) begin
          sum_d                     = sum_new;
          cdf_d[acc_n_q[AW-1:0]]    = sum_new;
          acc_n_d                   = acc_n_q + 1'b1;
          if (last_i || acc_n_q == IW'(C_QUANTITY - 1)) state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        if (!div_busy && lnch_q < IW'(C_QUANTITY)) begin
          div_start = 1'b1;
          lnch_d    = lnch_q + 1'b1;
        end
        if (div_done) begin
          valid_o_d = 1'b1;
          last_o_d  = (lnch_q == IW'(C_QUANTITY));
          data_o_d  = (sum_q == '0) ? '0 : div_quo;
        end
        if (valid_o_q && last_o_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      sum_q     <= '0;
      acc_n_q   <= '0;
      lnch_q    <= '0;
      valid_o_q <= 1'b0;
      last_o_q  <= 1'b0;
      data_o_q  <= '0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      acc_n_q   <= acc_n_d;
      lnch_q    <= lnch_d;
      valid_o_q <= valid_o_d;
      last_o_q  <= last_o_d;
      data_o_q  <= data_o_d;
    end
  end

  always_ff @(posedge clk_i) begin
    cdf_q <= cdf_d;
  end

  assign busy_o  = (state_q == ST_NORM);
  assign valid_o = valid_o_q;
  assign last_o  = last_o_q;
  assign data_o  = data_o_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_histogram_cdf.sv
// Directed frame table plus hand-written gap, noise and reset sequences for histogram_cdf.
module tb_histogram_cdf;
  import histogram_pkg::*;

  localparam int Q  = 16;
  localparam int PW = 28;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        valid_i = 1'b0;
  logic        last_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        busy_o, valid_o, last_o;
  logic [7:0]  data_o;
  hist_state_e state_o;

  histogram_cdf dut (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .valid_i (valid_i),
    .last_i  (last_i),
    .data_i  (data_i),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .data_o  (data_o),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  typedef struct packed {
    logic [15:0][15:0] cnt;
    logic [15:0][7:0]  lvl;
    logic [4:0]        n;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_frame(input vec_t v, input bit gaps);
    for (int k = 0; k < int'(v.n); k++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        repeat (g) begin
          @(negedge clk);
          valid_i = 1'b0;
          last_i  = 1'($urandom_range(0, 1));
          data_i  = 16'($urandom);
        end
      end
      @(negedge clk);
      valid_i = 1'b1;
      last_i  = (k == int'(v.n) - 1);
      data_i  = v.cnt[k];
    end
    @(negedge clk);
    valid_i = 1'b0;
    last_i  = 1'b0;
    data_i  = '0;
  endtask

  task automatic load_exp(input vec_t v);
    for (int i = 0; i < Q; i++) exp_q.push_back({(i == Q - 1), v.lvl[i]});
  endtask

  task automatic collect_frame(input string tag);
    int t_busy, t_prev, waited;
    logic [8:0] e;
    t_busy = -1;
    t_prev = 0;
    for (int b = 0; b < Q; b++) begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
        if (busy_o && t_busy < 0) t_busy = cyc;
      end while (!valid_o && waited < 400);
      if (!valid_o) begin
        checks++;
        errors++;
        $display("FAIL %s beat %0d timeout: no valid_o within 400 cycles, expected a beat", tag, b);
        exp_q.delete();
        return;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h0;
      check($sformatf("%s bin%0d level", tag, b), 32'(data_o), 32'(e[7:0]));
      check($sformatf("%s bin%0d last_o", tag, b), 32'(last_o), 32'(e[8]));
      check($sformatf("%s bin%0d busy_o", tag, b), 32'(busy_o), 32'd1);
      if (b == 0) check($sformatf("%s first latency", tag), 32'(cyc - t_busy), 32'(PW + 1));
      else        check($sformatf("%s bin%0d spacing", tag, b), 32'(cyc - t_prev), 32'(PW + 1));
      t_prev = cyc;
    end
    @(negedge clk);
    check($sformatf("%s valid_o after last", tag), 32'(valid_o), 32'd0);
    check($sformatf("%s busy_o after last", tag), 32'(busy_o), 32'd0);
  endtask

  task automatic hold_valid_in_norm();
    int w;
    w = 0;
    while (busy_o && w < 2000) begin
      valid_i = 1'b1;
      last_i  = 1'($urandom_range(0, 1));
      data_i  = 16'($urandom);
      @(negedge clk);
      w++;
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
    data_i  = '0;
  endtask

  initial begin
    for (int i = 0; i < 6; i++) vecs[i] = '0;
    vecs[0].cnt = {16{16'd1}};
    vecs[0].n   = 5'd16;
    vecs[0].lvl = {8'd255, 8'd239, 8'd223, 8'd207, 8'd191, 8'd175, 8'd159, 8'd143,
                   8'd127, 8'd111, 8'd95,  8'd79,  8'd63,  8'd47,  8'd31,  8'd15};
    vecs[1].cnt[3] = 16'd100;
    vecs[1].n      = 5'd16;
    vecs[1].lvl    = {{13{8'd255}}, {3{8'd0}}};
    vecs[2].cnt[0] = 16'd10;
    vecs[2].cnt[1] = 16'd20;
    vecs[2].cnt[2] = 16'd30;
    vecs[2].cnt[3] = 16'd40;
    vecs[2].n      = 5'd4;
    vecs[2].lvl    = {{13{8'd255}}, 8'd153, 8'd76, 8'd25};
    vecs[3].n      = 5'd16;
    vecs[4].cnt[0] = 16'd7;
    vecs[4].n      = 5'd1;
    vecs[4].lvl    = {16{8'd255}};
    vecs[5].cnt    = {16{16'hFFFF}};
    vecs[5].n      = 5'd16;
    vecs[5].lvl    = vecs[0].lvl;

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset valid_o", 32'(valid_o), 32'd0);
    check("reset last_o", 32'(last_o), 32'd0);
    check("reset data_o", 32'(data_o), 32'd0);
    check("reset busy_o", 32'(busy_o), 32'd0);
    check("reset state", 32'(state_o), 32'(ST_IDLE));
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      load_exp(vecs[i]);
      fork
        send_frame(vecs[i], 1'b0);
        collect_frame($sformatf("vec%0d", i));
      join
      repeat (2) @(negedge clk);
    end

    load_exp(vecs[1]);
    fork
      begin
        send_frame(vecs[1], 1'b1);
        hold_valid_in_norm();
      end
      collect_frame("gap_noise");
    join
    load_exp(vecs[2]);
    fork
      send_frame(vecs[2], 1'b1);
      collect_frame("after_noise");
    join

    begin
      int seen, w, stray;
      seen = 0;
      w    = 0;
      fork
        send_frame(vecs[0], 1'b0);
        while (seen < 3 && w < 1000) begin
          @(negedge clk);
          w++;
          if (valid_o) seen++;
        end
      join
      check("mid-norm beats before reset", 32'(seen), 32'd3);
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      check("mid-norm reset valid_o", 32'(valid_o), 32'd0);
      check("mid-norm reset last_o", 32'(last_o), 32'd0);
      check("mid-norm reset data_o", 32'(data_o), 32'd0);
      check("mid-norm reset busy_o", 32'(busy_o), 32'd0);
      stray = 0;
      repeat (80) begin
        @(negedge clk);
        if (valid_o || busy_o) stray++;
      end
      check("stale beats after reset", 32'(stray), 32'd0);
    end

    load_exp(vecs[2]);
    fork
      send_frame(vecs[2], 1'b0);
      collect_frame("post_reset");
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/histogram_cdf.md
HISTOGRAM_CDF -- requirements
Module: histogram_cdf

Interface
REQ-001 Parameter C_QUANTITY, 16: number of histogram bins per frame.
REQ-002 Parameter C_COUNT_WIDTH, 16: width of one bin count.
REQ-003 Parameter C_DATA_WIDTH, 8: width of one output equalised level.
REQ-004 Port clk_i  input  1: single clock; all logic on its rising edge.
REQ-005 Port rstn_i  input  1: reset, synchronous, active-low.
REQ-006 Port valid_i  input  1: data_i carries a bin count this cycle.
REQ-007 Port last_i  input  1: final bin of the frame; qualified by valid_i.
REQ-008 Port data_i  input  C_COUNT_WIDTH: bin count, bins in ascending order starting at bin 0.
REQ-009 Port busy_o  output  1: block is in NORM; input beats are ignored.
REQ-010 Port valid_o  output  1: data_o carries one equalised level.
REQ-011 Port last_o  output  1: level for bin C_QUANTITY-1; asserted with valid_o.
REQ-012 Port data_o  output  C_DATA_WIDTH: equalised level for the current bin.

Function
REQ-013 Widths: SUM_W = C_COUNT_WIDTH + clog2(C_QUANTITY) (20 at defaults); P = SUM_W + C_DATA_WIDTH (28 at defaults). The running sum is never saturated.
REQ-014 States are IDLE, ACCUM and NORM.
- IDLE: first valid_i beat goes to ACCUM.
- ACCUM: collects beats.
- NORM: emits levels; returns to IDLE after the last_o beat.
REQ-015 Accepted beat k (k = 0..C_QUANTITY-1): sum += data_i; cdf[k] = new sum. Beat 0 also loads sum = data_i from IDLE.
REQ-016 Accumulation ends on the beat with last_i=1 or on beat C_QUANTITY-1, whichever comes first; NORM is entered the next cycle.
REQ-017 Early end: if last_i arrives on beat k < C_QUANTITY-1, bins k+1..C_QUANTITY-1 take cdf = total (zero count).
REQ-018 Level per bin, computed in bin order: floor(cdf[i] * (2^C_DATA_WIDTH - 1) / total).
- Division is sequential: 1 launch cycle plus P iteration cycles.
- Output beats are spaced exactly P+1 cycles apart; the first beat appears P+1 cycles after NORM entry.
REQ-019 If total == 0, every level is 0 and the timing is unchanged.
REQ-020 valid_o, last_o and data_o are registered; valid_o is high for exactly one cycle per bin; exactly C_QUANTITY beats are emitted per frame.
REQ-021 busy_o is high for every NORM cycle and low otherwise.
- valid_i in NORM is ignored; no state changes.
- A beat on the cycle NORM exits to IDLE is also ignored.
REQ-022 valid_i=0 in ACCUM is a stall: no state or sum change.
REQ-023 last_i with valid_i=0 has no effect.

Reset
REQ-024 While rstn_i=0 at a clock edge:
- state = IDLE; sum, bin index and divider state cleared;
- valid_o, last_o, busy_o and data_o = 0.
REQ-025 Reset in any state, including mid-division, aborts the frame with no further output beats; the cdf buffer need not be cleared.

Structure
REQ-026 Package histogram_pkg holds C_QUANTITY, C_COUNT_WIDTH and C_DATA_WIDTH defaults, the SUM_W/P derivations and the state enumeration, shared with the Histogram block.
REQ-027 The cdf buffer is a C_QUANTITY x SUM_W register array inside histogram_cdf.
REQ-028 One sub-module, seq_divider (restoring, unsigned, start/done handshake, P-bit dividend, SUM_W-bit divisor), performs REQ-018's division.

Verification
REQ-029 16 beats of count 1, last_i on beat 15 -> total 16; levels floor((i+1)*255/16): bin0=15, bin7=127, bin15=255; last_o only on bin 15.
REQ-030 Count 100 on bin 3, all other bins 0 -> bins 0-2 = 0, bins 3-15 = 255.
REQ-031 4 beats 10,20,30,40 with last_i on beat 3 -> levels 25, 76, 153, 255, then bins 4-15 = 255; 16 output beats.
REQ-032 16 zero counts -> 16 beats of 0; beat spacing P+1 = 29 cycles.
REQ-033 Random valid_i gaps during ACCUM, plus valid_i held high throughout NORM -> gaps and NORM beats have no effect; the next frame's levels are correct.
REQ-034 rstn_i low for 1 cycle mid-NORM -> all outputs 0 the following cycle and no stale beats; a new frame after release produces correct levels.
